ea_seq: RTL and testbench
=========================

EA_SEQ -- requirements
Module: ea_seq

Interface
REQ-001 Parameter DATA_W, default 8: data/index width.
REQ-002 Parameter ADDR_W, default 16: address width; SHALL equal 2*DATA_W.
REQ-003 Parameter ZP_WRAP, default 1: 1 = zero-page index/pointer sums wrap within page 0.
REQ-004 Parameter JMP_BUG, default 1: 1 = IND high-byte fetch does not carry into the pointer high byte.
REQ-005 Port clk  in  1  clock; all state changes on rising edge.
REQ-006 Port reset_n  in  1  reset; one clock, reset asynchronous and active-low.
REQ-007 Port start  in  1  request; accepted only in IDLE with ready=1.
REQ-008 Port mode  in  4  addressing mode: 0 IMM, 1 ZP, 2 ZPX, 3 ZPY, 4 ABS, 5 ABSX, 6 ABSY, 7 INDX, 8 INDY, 9 IND; 10-15 reserved.
REQ-009 Port store  in  1  request is a write; sampled with start.
REQ-010 Port idx_x, idx_y  in  DATA_W  index registers; sampled when used.
REQ-011 Port pc  in  ADDR_W  current program counter.
REQ-012 Port d_in  in  DATA_W  bus read data, valid in the cycle addr is driven.
REQ-013 Port ready  in  1  bus ready; 0 stalls the sequencer.
REQ-014 Port addr  out  ADDR_W  bus address.
REQ-015 Port write  out  1  bus write strobe.
REQ-016 Port pc_inc  out  1  PC advance request, one per operand byte consumed.
REQ-017 Port busy  out  1  high in every state except IDLE.
REQ-018 Port done  out  1  one-cycle pulse; ea, page_cross, err valid.
REQ-019 Port ea  out  ADDR_W  effective address (registered).
REQ-020 Port page_cross, err  out  1 each  index carried into high byte; reserved mode.

Function
REQ-021 States: IDLE, OP_LO, OP_HI, ZP_DUMMY, PTR_LO, PTR_HI, FIX, DATA; DATA is the final bus cycle.
REQ-022 Latency (start cycle = 0, ready=1): IMM 1, ZP 2, ZPX/ZPY 3, ABS 3, ABSX/ABSY 3 (4 if carry or store), INDX 5, INDY 4 (5 if carry or store), IND 5; done asserted in DATA.
REQ-023 OP_LO/OP_HI: addr=pc, pc_inc=1, d_in captured as base low/high byte.
REQ-024 ZPX/ZPY/INDX: ZP_DUMMY reads {0,base}; sum base+index; ZP_WRAP=1 discards carry, ZP_WRAP=0 propagates it into high byte.
REQ-025 INDX: PTR_LO reads {0,p}, PTR_HI reads {0,p+1} (wrap per ZP_WRAP); INDY: same with p=operand, then low byte + idx_y.
REQ-026 ABSX/ABSY/INDY: low sum carry sets page_cross and inserts FIX reading {unadjusted high, summed low}; store=1 always inserts FIX, page_cross still reflects carry.
REQ-027 IND: PTR_LO reads {H,L}; PTR_HI reads {H,L+1} if JMP_BUG=1, else full ADDR_W increment of {H,L}.
REQ-028 DATA: addr=ea, write=store; IMM: ea=pc, pc_inc=1, write=0 regardless of store.
REQ-029 Reserved mode: DATA entered at cycle 1 with err=1, ea=pc, write=0, pc_inc=0.
REQ-030 ready=0: state, captured bytes, addr and write held; pc_inc and done forced 0; stall may extend any state including DATA.
REQ-031 IDLE: addr=pc, write=0, pc_inc=0; start ignored while busy or ready=0.
REQ-032 DATA with ready=1 returns to IDLE; next start accepted the following cycle (no back-to-back overlap).
REQ-033 All address arithmetic modulo 2^ADDR_W; ea wraps from max to 0.

Reset
REQ-034 reset_n low SHALL immediately force IDLE, busy=0, done=0, write=0, pc_inc=0, page_cross=0, err=0, ea=0, addr=pc.
REQ-035 Reset mid-sequence SHALL abandon the sequence with no write and no done; first start after release accepted normally.

Structure
REQ-036 Shared package cpu_pkg SHALL hold the mode enum, state enum, and default DATA_W/ADDR_W.
REQ-037 One sub-module ea_add: DATA_W adder with carry-in/carry-out, used for index and pointer sums.

Verification
REQ-038 ABSX, X=0x10, operands 0xF8,0x12, load -> done cycle 4, ea=0x1308, page_cross=1, FIX addr 0x1208.
REQ-039 ZPX, X=0x20, operand 0xF0, ZP_WRAP=1 -> ea=0x0010, done cycle 3; ZP_WRAP=0 -> ea=0x0110.
REQ-040 IND at 0x02FF, JMP_BUG=1 -> PTR_HI addr 0x0200; JMP_BUG=0 -> 0x0300.
REQ-041 INDY store, ptr 0x40, mem 0x00/0x30, Y=0x05 -> FIX inserted, DATA addr 0x3005, write=1, page_cross=0, done cycle 5.
REQ-042 ABS with ready=0 for 3 cycles in OP_HI -> addr held, pc_inc=0 while stalled, done at cycle 6, exactly 2 pc_inc pulses.
REQ-043 reset_n low during INDX PTR_LO -> busy=0, no write, no done; subsequent ZP completes in 2 cycles.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU-side types for the address sequencer: addressing modes,
// sequencer states and default datapath widths.
package cpu_pkg;
    localparam int CPU_DATA_W = 8;
    localparam int CPU_ADDR_W = 16;

    typedef enum logic [3:0] {
        MODE_IMM  = 4'd0,
        MODE_ZP   = 4'd1,
        MODE_ZPX  = 4'd2,
        MODE_ZPY  = 4'd3,
        MODE_ABS  = 4'd4,
        MODE_ABSX = 4'd5,
        MODE_ABSY = 4'd6,
        MODE_INDX = 4'd7,
        MODE_INDY = 4'd8,
        MODE_IND  = 4'd9
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OP_LO,
        ST_OP_HI,
        ST_ZP_DUMMY,
        ST_PTR_LO,
        ST_PTR_HI,
        ST_FIX,
        ST_DATA
    } state_e;

    function automatic logic uses_y(input mode_e m);
        return (m == MODE_ZPY) || (m == MODE_ABSY) || (m == MODE_INDY);
    endfunction

    function automatic logic is_reserved(input logic [3:0] m);
        return m > 4'd9;
    endfunction
endpackage

// File: rtl/ea_add.sv
// Byte-wide adder with carry in/out for index and pointer sums.
module ea_add #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         ci_i,
    output logic [W-1:0] sum_o,
    output logic         co_o
);
    assign {co_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, ci_i};
endmodule

// File: rtl/ea_seq.sv
// Effective-address sequencer: walks operand/pointer fetches for each
// addressing mode and finishes with one DATA bus cycle at the computed ea.
module ea_seq
    import cpu_pkg::*;
#(
    parameter int DATA_W  = CPU_DATA_W,
    parameter int ADDR_W  = CPU_ADDR_W,
    parameter int ZP_WRAP = 1,
    parameter int JMP_BUG = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [3:0]        mode,
    input  logic              store,
    input  logic [DATA_W-1:0] idx_x,
    input  logic [DATA_W-1:0] idx_y,
    input  logic [ADDR_W-1:0] pc,
    input  logic [DATA_W-1:0] d_in,
    input  logic              ready,
    output logic [ADDR_W-1:0] addr,
    output logic              write,
    output logic              pc_inc,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ea,
    output logic              page_cross,
    output logic              err
);
    localparam logic [DATA_W-1:0] ZERO = '0;

    state_e            state_q, state_d;
    mode_e             mode_q, mode_d;
    logic              store_q, store_d, pcross_q, pcross_d, err_q, err_d;
    logic [DATA_W-1:0] lo_q, lo_d, hi_q, hi_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d, ea_q, ea_d;

    logic [DATA_W-1:0] idx, isum, inc_sum;
    logic              icarry, inc_co;
    logic [ADDR_W-1:0] zp_ptr, ptr_inc, ptr_hi_addr, idx_ea;

    assign idx = uses_y(mode_q) ? idx_y : idx_x;

    // lo_q always holds the byte to be indexed: operand low or pointer low data
    ea_add #(.W(DATA_W)) u_idx (
        .a_i(lo_q), .b_i(idx), .ci_i(1'b0), .sum_o(isum), .co_o(icarry)
    );
    ea_add #(.W(DATA_W)) u_inc (
        .a_i(ptr_q[DATA_W-1:0]), .b_i(ZERO), .ci_i(1'b1), .sum_o(inc_sum), .co_o(inc_co)
    );

    assign zp_ptr  = (ZP_WRAP != 0) ? {ZERO, isum} : {{(DATA_W-1){1'b0}}, icarry, isum};
    assign ptr_inc = {ptr_q[ADDR_W-1:DATA_W] + {{(DATA_W-1){1'b0}}, inc_co}, inc_sum};
    assign idx_ea  = {d_in + {{(DATA_W-1){1'b0}}, icarry}, isum};

    always_comb begin
        if (mode_q == MODE_IND)
            ptr_hi_addr = (JMP_BUG != 0) ? {ptr_q[ADDR_W-1:DATA_W], inc_sum} : ptr_inc;
        else
            ptr_hi_addr = (ZP_WRAP != 0) ? {ZERO, inc_sum} : ptr_inc;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_IMM;
            store_q  <= 1'b0;
            pcross_q <= 1'b0;
            err_q    <= 1'b0;
            lo_q     <= '0;
            hi_q     <= '0;
            ptr_q    <= '0;
            ea_q     <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            store_q  <= store_d;
            pcross_q <= pcross_d;
            err_q    <= err_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            ptr_q    <= ptr_d;
            ea_q     <= ea_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        store_d  = store_q;
        pcross_d = pcross_q;
        err_d    = err_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        ptr_d    = ptr_q;
        ea_d     = ea_q;
        if (ready) begin
            case (state_q)
                ST_IDLE: if (start) begin
                    mode_d   = is_reserved(mode) ? MODE_IMM : mode_e'(mode);
                    store_d  = store;
                    pcross_d = 1'b0;
                    err_d    = is_reserved(mode);
                    if (is_reserved(mode) || mode_e'(mode) == MODE_IMM) begin
                        ea_d    = pc;
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_OP_LO;
                    end
                end
                ST_OP_LO: begin
                    lo_d = d_in;
                    case (mode_q)
                        MODE_ZP: begin ea_d = {ZERO, d_in}; state_d = ST_DATA; end
                        MODE_ZPX, MODE_ZPY, MODE_INDX: state_d = ST_ZP_DUMMY;
                        MODE_INDY: begin ptr_d = {ZERO, d_in}; state_d = ST_PTR_LO; end
                        default: state_d = ST_OP_HI;
                    endcase
                end
                ST_OP_HI: begin
                    hi_d = d_in;
                    case (mode_q)
                        MODE_ABSX, MODE_ABSY: begin
                            pcross_d = icarry;
                            ea_d     = idx_ea;
                            state_d  = (icarry || store_q) ? ST_FIX : ST_DATA;
                        end
                        MODE_IND: begin ptr_d = {d_in, lo_q}; state_d = ST_PTR_LO; end
                        default: begin ea_d = {d_in, lo_q}; state_d = ST_DATA; end
                    endcase
                end
                ST_ZP_DUMMY: begin
                    if (mode_q == MODE_INDX) begin
                        ptr_d   = zp_ptr;
                        state_d = ST_PTR_LO;
                    end else begin
                        ea_d    = zp_ptr;
                        state_d = ST_DATA;
                    end
                end
                ST_PTR_LO: begin lo_d = d_in; state_d = ST_PTR_HI; end
                ST_PTR_HI: begin
                    hi_d = d_in;
                    if (mode_q == MODE_INDY) begin
                        pcross_d = icarry;
                        ea_d     = idx_ea;
                        state_d  = (icarry || store_q) ? ST_FIX : ST_DATA;
                    end else begin
                        ea_d    = {d_in, lo_q};
                        state_d = ST_DATA;
                    end
                end
                ST_FIX:  state_d = ST_DATA;
                ST_DATA: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Bus outputs are pure state decode so reset forces them at once
    always_comb begin
        addr   = pc;
        write  = 1'b0;
        pc_inc = 1'b0;
        done   = 1'b0;
        case (state_q)
            ST_OP_LO, ST_OP_HI: pc_inc = ready;
            ST_ZP_DUMMY:        addr = {ZERO, lo_q};
            ST_PTR_LO:          addr = ptr_q;
            ST_PTR_HI:          addr = ptr_hi_addr;
            ST_FIX:             addr = {hi_q, ea_q[DATA_W-1:0]};
            ST_DATA: begin
                addr   = ea_q;
                write  = store_q && !err_q && (mode_q != MODE_IMM);
                pc_inc = ready && !err_q && (mode_q == MODE_IMM);
                done   = ready;
            end
            default: ;
        endcase
    end

    assign busy       = (state_q != ST_IDLE);
    assign ea         = ea_q;
    assign page_cross = pcross_q;
    assign err        = err_q;
endmodule

// File: tb/tb_ea_seq.sv
// Bench for ea_seq: two instances (wrap/bug on and off) in lockstep against
// an arithmetic reference model, directed cases then randomized traffic.
module tb_ea_seq;
    logic        clk = 1'b0;
    logic        reset_n, start, store, ready;
    logic [3:0]  mode;
    logic [7:0]  idx_x, idx_y, d_in1, d_in2;
    logic [15:0] pc, addr1, addr2, ea1, ea2;
    logic        write1, write2, pc_inc1, pc_inc2, busy1, busy2, done1, done2;
    logic        pcx1, pcx2, err1, err2;
    logic [7:0]  mem [0:65535];

    int checks = 0;
    int errors = 0;
    int done_c1, done_c2, npc, nwr;
    logic [15:0] tr_a1 [0:63];
    logic [15:0] tr_a2 [0:63];
    logic [15:0] ea_at1, ea_at2, addr_at1;
    logic        pcx_at1, pcx_at2, err_at1;

    always #5 clk = ~clk;
    assign d_in1 = mem[addr1];
    assign d_in2 = mem[addr2];

    ea_seq #(.DATA_W(8), .ADDR_W(16), .ZP_WRAP(1), .JMP_BUG(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .store(store),
        .idx_x(idx_x), .idx_y(idx_y), .pc(pc), .d_in(d_in1), .ready(ready),
        .addr(addr1), .write(write1), .pc_inc(pc_inc1), .busy(busy1), .done(done1),
        .ea(ea1), .page_cross(pcx1), .err(err1));

    ea_seq #(.DATA_W(8), .ADDR_W(16), .ZP_WRAP(0), .JMP_BUG(0)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .store(store),
        .idx_x(idx_x), .idx_y(idx_y), .pc(pc), .d_in(d_in2), .ready(ready),
        .addr(addr2), .write(write2), .pc_inc(pc_inc2), .busy(busy2), .done(done2),
        .ea(ea2), .page_cross(pcx2), .err(err2));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rd(input int a);
        return int'(mem[a & 16'hFFFF]);
    endfunction

    // Reference: ea, page cross, error, done cycle and operand bytes consumed
    task automatic model(input int m, input bit st, input int x, input int y, input int pc0,
                         input bit zpw, input bit jb, output int ea, output bit pcx,
                         output bit er, output int lat, output int nop);
        int p, lo, hi, i;
        ea = pc0; pcx = 1'b0; er = 1'b0; lat = 1; nop = 0;
        i = (m == 3 || m == 6 || m == 8) ? y : x;
        case (m)
            0: nop = 1;
            1: begin ea = rd(pc0); lat = 2; nop = 1; end
            2, 3: begin p = rd(pc0) + i; ea = zpw ? p % 256 : p; lat = 3; nop = 1; end
            4: begin ea = rd(pc0) + 256 * rd(pc0 + 1); lat = 3; nop = 2; end
            5, 6: begin
                lo = rd(pc0);
                pcx = (lo + i) > 255;
                ea = (lo + 256 * rd(pc0 + 1) + i) % 65536;
                lat = (pcx || st) ? 4 : 3; nop = 2;
            end
            7: begin
                p = rd(pc0) + x;
                if (zpw) p = p % 256;
                lo = rd(p); hi = rd(zpw ? (p + 1) % 256 : p + 1);
                ea = lo + 256 * hi; lat = 5; nop = 1;
            end
            8: begin
                p = rd(pc0);
                lo = rd(p); hi = rd(zpw ? (p + 1) % 256 : p + 1);
                pcx = (lo + y) > 255;
                ea = (lo + 256 * hi + y) % 65536;
                lat = (pcx || st) ? 5 : 4; nop = 1;
            end
            9: begin
                p = rd(pc0) + 256 * rd(pc0 + 1);
                lo = rd(p);
                hi = rd(jb ? ((p & 16'hFF00) | ((p + 1) & 16'h00FF)) : (p + 1) % 65536);
                ea = lo + 256 * hi; lat = 5; nop = 2;
            end
            default: er = 1'b1;
        endcase
    endtask

    // Enter just after a rising edge; returns just after a rising edge.
    task automatic run(input int m, input bit st, input int ss, input int sn);
        logic inc;
        done_c1 = -1; done_c2 = -1; npc = 0; nwr = 0;
        mode = 4'(m); store = st; start = 1'b1;
        for (int c = 0; c < 40 && (done_c1 < 0 || done_c2 < 0); c++) begin
            ready = !(c >= ss && c < ss + sn);
            @(negedge clk);
            tr_a1[c] = addr1; tr_a2[c] = addr2;
            inc = pc_inc1;
            if (pc_inc1) npc++;
            if (write1 && ready) nwr++;
            if (done1) begin
                done_c1 = c; ea_at1 = ea1; pcx_at1 = pcx1; err_at1 = err1; addr_at1 = addr1;
            end
            if (done2) begin done_c2 = c; ea_at2 = ea2; pcx_at2 = pcx2; end
            @(posedge clk); #1;
            if (inc) pc = pc + 16'd1;
            start = 1'b0;
        end
        ready = 1'b1;
    endtask

    task automatic txn(input string nm, input int m, input bit st, input int ss, input int sn);
        int e1, e2, l1, l2, n1, n2, pc0, wexp;
        bit p1, p2, r1, r2;
        pc0 = int'(pc);
        model(m, st, int'(idx_x), int'(idx_y), pc0, 1'b1, 1'b1, e1, p1, r1, l1, n1);
        model(m, st, int'(idx_x), int'(idx_y), pc0, 1'b0, 1'b0, e2, p2, r2, l2, n2);
        wexp = (st && m >= 1 && m <= 9) ? 1 : 0;
        if (ss >= 1 && ss <= l1) l1 = l1 + sn;
        run(m, st, ss, sn);
        check({nm, ".done_cyc"}, 32'(done_c1), 32'(l1));
        check({nm, ".done_cyc2"}, 32'(done_c2), 32'(l1));
        check({nm, ".ea"}, 32'(ea_at1), 32'(e1));
        check({nm, ".ea_nowrap"}, 32'(ea_at2), 32'(e2));
        check({nm, ".addr_data"}, 32'(addr_at1), 32'(e1));
        check({nm, ".page_cross"}, 32'(pcx_at1), 32'(p1));
        check({nm, ".page_cross2"}, 32'(pcx_at2), 32'(p2));
        check({nm, ".err"}, 32'(err_at1), 32'(r1));
        check({nm, ".pc_inc_cnt"}, 32'(npc), 32'(n1));
        check({nm, ".write_cnt"}, 32'(nwr), 32'(wexp));
    endtask

    initial begin
        int m, ss, sn;
        logic inc;
        reset_n = 1'b0; start = 1'b0; ready = 1'b1; store = 1'b0; mode = 4'd0;
        idx_x = 8'd0; idx_y = 8'd0; pc = 16'h1234;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

        @(negedge clk);
        check("rst.busy", 32'(busy1), 32'd0);
        check("rst.done", 32'(done1), 32'd0);
        check("rst.write", 32'(write1), 32'd0);
        check("rst.pc_inc", 32'(pc_inc1), 32'd0);
        check("rst.page_cross", 32'(pcx1), 32'd0);
        check("rst.err", 32'(err1), 32'd0);
        check("rst.ea", 32'(ea1), 32'd0);
        check("rst.addr", 32'(addr1), 32'h1234);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // ABSX with carry: FIX reads unadjusted high byte
        pc = 16'h0400; mem[16'h0400] = 8'hF8; mem[16'h0401] = 8'h12; idx_x = 8'h10;
        txn("absx", 5, 1'b0, 99, 0);
        check("absx.ea_k", 32'(ea_at1), 32'h1308);
        check("absx.fix_addr", 32'(tr_a1[3]), 32'h1208);
        check("absx.done_k", 32'(done_c1), 32'd4);
        check("absx.pcx_k", 32'(pcx_at1), 32'd1);

        pc = 16'h0500; mem[16'h0500] = 8'hF0; idx_x = 8'h20;
        txn("zpx", 2, 1'b0, 99, 0);
        check("zpx.wrap_ea", 32'(ea_at1), 32'h0010);
        check("zpx.nowrap_ea", 32'(ea_at2), 32'h0110);

        pc = 16'h0600; mem[16'h0600] = 8'hFF; mem[16'h0601] = 8'h02;
        txn("ind", 9, 1'b0, 99, 0);
        check("ind.ptr_lo", 32'(tr_a1[3]), 32'h02FF);
        check("ind.bug_hi", 32'(tr_a1[4]), 32'h0200);
        check("ind.nobug_hi", 32'(tr_a2[4]), 32'h0300);

        pc = 16'h0700; mem[16'h0700] = 8'h40; mem[16'h0040] = 8'h00; mem[16'h0041] = 8'h30;
        idx_y = 8'h05;
        txn("indy_st", 8, 1'b1, 99, 0);
        check("indy_st.done_k", 32'(done_c1), 32'd5);
        check("indy_st.fix_addr", 32'(tr_a1[4]), 32'h3005);
        check("indy_st.addr_k", 32'(addr_at1), 32'h3005);
        check("indy_st.wr_k", 32'(nwr), 32'd1);
        check("indy_st.pcx_k", 32'(pcx_at1), 32'd0);

        // three-cycle stall while in OP_HI
        pc = 16'h0800;
        txn("abs_stall", 4, 1'b0, 2, 3);
        check("abs_stall.done_k", 32'(done_c1), 32'd6);
        check("abs_stall.pcinc_k", 32'(npc), 32'd2);
        check("abs_stall.addr_held", 32'(tr_a1[4]), 32'h0801);
        check("abs_stall.pc_end", 32'(pc), 32'h0802);

        pc = 16'h0900; mem[16'h0900] = 8'hFF; mem[16'h0901] = 8'hFF; idx_x = 8'h01;
        txn("absx_wrap", 5, 1'b0, 99, 0);
        check("absx_wrap.ea_k", 32'(ea_at1), 32'h0000);

        txn("imm_st", 0, 1'b1, 99, 0);
        txn("rsv", 12, 1'b1, 99, 0);
        check("rsv.err_k", 32'(err_at1), 32'd1);

        // reset while INDX sits in PTR_LO
        pc = 16'h0A00; mem[16'h0A00] = 8'h10; idx_x = 8'h00;
        mode = 4'd7; store = 1'b1; start = 1'b1; ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            inc = pc_inc1;
            @(posedge clk); #1;
            if (inc) pc = pc + 16'd1;
            start = 1'b0;
        end
        check("rst_mid.pre_busy", 32'(busy1), 32'd1);
        check("rst_mid.ptr_addr", 32'(addr1), 32'h0010);
        reset_n = 1'b0; #1;
        check("rst_mid.busy", 32'(busy1), 32'd0);
        check("rst_mid.busy2", 32'(busy2), 32'd0);
        check("rst_mid.addr", 32'(addr1), 32'(pc));
        check("rst_mid.ea", 32'(ea1), 32'd0);
        @(negedge clk);
        check("rst_mid.write", 32'(write1), 32'd0);
        check("rst_mid.done", 32'(done1), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        txn("zp_after", 1, 1'b0, 99, 0);
        check("zp_after.done_k", 32'(done_c1), 32'd2);

        for (int t = 0; t < 120; t++) begin
            m = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
            idx_x = 8'($urandom); idx_y = 8'($urandom); pc = 16'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                ss = int'($urandom_range(1, 5)); sn = int'($urandom_range(1, 3));
            end else begin
                ss = 99; sn = 0;
            end
            txn("rand", m, 1'($urandom), ss, sn);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
